// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: default geometry and edge-mode encodings used by
// gpio_in, wb_gpio and gpio_out.
package gpio_pkg;
  localparam int  GPIO_WIDTH       = 8;
  localparam int  GPIO_SYNC_STAGES = 2;
  localparam int  GPIO_FILT_LEN    = 0;
  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;
endpackage

// File: rtl/gpio_in_bit.sv
// One GPIO input bit: metastability synchronizer, glitch-filter counter and
// the registered data bit, plus a flag marking a filtered (non-warm-up) update.
module gpio_in_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int FILT_LEN    = GPIO_FILT_LEN
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  input  logic bypass_i,
  output logic data_o,
  output logic chg_o
);
  localparam int CW = (FILT_LEN == 0) ? 1 : $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] FL = CW'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   chg_q, chg_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    cnt_d  = '0;
    data_d = data_q;
    chg_d  = 1'b0;
    if (bypass_i) begin
      data_d = sync;
    end else if (sync != data_q) begin
      // The pin must disagree for FILT_LEN+1 consecutive cycles to be accepted.
      if (cnt_q == FL) begin
        data_d = sync;
        chg_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      data_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      chg_q  <= chg_d;
    end
  end

  assign data_o = data_q;
  assign chg_o  = chg_q;
endmodule

// File: rtl/gpio_in.sv
// GPIO input block: per-bit synchronize/filter lanes, post-reset warm-up,
// edge-event detection, sticky pending flags and a masked interrupt.
module gpio_in
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int FILT_LEN    = GPIO_FILT_LEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] irq_en_i,
  input  logic [WIDTH-1:0] irq_edge_i,
  input  logic [WIDTH-1:0] irq_both_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] pend_o,
  output logic             irq_o
);
  localparam int WARM = SYNC_STAGES + 1;

  logic [2:0]       warm_q, warm_d;
  logic             warm;
  logic [WIDTH-1:0] chg, ev;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             irq_q, irq_d;

  assign warm = (warm_q != 3'(WARM));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
    ) u_bit (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (pad_i[i]),
      .bypass_i(warm),
      .data_o  (data_o[i]),
      .chg_o   (chg[i])
    );
  end

  always_comb begin
    warm_d = warm ? warm_q + 3'd1 : warm_q;
    for (int i = 0; i < WIDTH; i++) begin
      ev[i] = chg[i] & (irq_both_i[i] |
                        (data_o[i] ? (irq_edge_i[i] == EDGE_RISE)
                                   : (irq_edge_i[i] == EDGE_FALL)));
    end
    // Set wins over a coincident clear so an event is never dropped.
    pend_d = (pend_q & ~irq_clr_i) | ev;
    irq_d  = |(pend_q & irq_en_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      warm_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      warm_q <= warm_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign pend_o = pend_q;
  assign irq_o  = irq_q;
endmodule

// File: tb/tb_gpio_in.sv
// Directed bench for gpio_in: three instances (FILT_LEN 0, 3, 5) share stimulus.
module tb_gpio_in;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pad, en, edg, both, clr;
  logic [7:0] d0, p0, d3, p3, d5, p5;
  logic       i0, i3, i5;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gpio_in #(.WIDTH(8), .SYNC_STAGES(2), .FILT_LEN(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .pad_i(pad), .irq_en_i(en), .irq_edge_i(edg),
    .irq_both_i(both), .irq_clr_i(clr), .data_o(d0), .pend_o(p0), .irq_o(i0));
  gpio_in #(.WIDTH(8), .SYNC_STAGES(2), .FILT_LEN(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .pad_i(pad), .irq_en_i(en), .irq_edge_i(edg),
    .irq_both_i(both), .irq_clr_i(clr), .data_o(d3), .pend_o(p3), .irq_o(i3));
  gpio_in #(.WIDTH(8), .SYNC_STAGES(2), .FILT_LEN(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .pad_i(pad), .irq_en_i(en), .irq_edge_i(edg),
    .irq_both_i(both), .irq_clr_i(clr), .data_o(d5), .pend_o(p5), .irq_o(i5));

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] pv);
    rst = 1'b1; pad = pv; en = '0; edg = '0; both = '0; clr = '0;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    rst = 1'b1; pad = 8'hFF; en = '0; edg = '0; both = '0; clr = '0;
    tick(2);
    nvec++; if (d0 !== 8'h00 || p0 !== 8'h00 || i0 !== 1'b0) begin nerr++; $display("FAIL rst_state d=%h p=%h i=%b want 00 00 0", d0, p0, i0); end
    rst = 1'b0;
    tick(2);
    nvec++; if (d3 !== 8'h00) begin nerr++; $display("FAIL warm_early d3=%h want 00", d3); end
    tick(1);
    nvec++; if (d0 !== 8'hFF) begin nerr++; $display("FAIL warm_d0 d=%h want ff", d0); end
    nvec++; if (d3 !== 8'hFF) begin nerr++; $display("FAIL warm_d3 d=%h want ff", d3); end
    tick(3);
    nvec++; if (p0 !== 8'h00 || i0 !== 1'b0 || p3 !== 8'h00) begin nerr++; $display("FAIL warm_noev p0=%h i0=%b p3=%h want 00 0 00", p0, i0, p3); end
  endtask

  task automatic test_rise;
    do_reset(8'h00);
    en = 8'h01; edg = 8'h01; pad = 8'h01;
    tick(2);
    nvec++; if (d0[0] !== 1'b0) begin nerr++; $display("FAIL rise_k2 d=%b want 0", d0[0]); end
    tick(1);
    nvec++; if (d0[0] !== 1'b1 || p0 !== 8'h00) begin nerr++; $display("FAIL rise_k3 d=%b p=%h want 1 00", d0[0], p0); end
    tick(1);
    nvec++; if (p0 !== 8'h01 || i0 !== 1'b0) begin nerr++; $display("FAIL rise_k4 p=%h i=%b want 01 0", p0, i0); end
    tick(1);
    nvec++; if (i0 !== 1'b1) begin nerr++; $display("FAIL rise_k5 i=%b want 1", i0); end
  endtask

  task automatic test_filter;
    int bad;
    do_reset(8'h00);
    both = 8'hFF;
    pad = 8'h02; tick(3); pad = 8'h00;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (d3[1] !== 1'b0) bad++;
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL filt_reject glitch_cycles=%0d want 0", bad); end
    nvec++; if (p3 !== 8'h00) begin nerr++; $display("FAIL filt_reject_pend p=%h want 00", p3); end
    pad = 8'h02; tick(4); pad = 8'h00;
    tick(1);
    nvec++; if (d3[1] !== 1'b0) begin nerr++; $display("FAIL filt_k5 d=%b want 0", d3[1]); end
    tick(1);
    nvec++; if (d3[1] !== 1'b1) begin nerr++; $display("FAIL filt_k6 d=%b want 1", d3[1]); end
    tick(1);
    nvec++; if (p3 !== 8'h02) begin nerr++; $display("FAIL filt_pend p=%h want 02", p3); end
  endtask

  task automatic test_both_clr;
    do_reset(8'h00);
    both = 8'h04; en = 8'h04;
    pad = 8'h04; tick(4);
    nvec++; if (p0 !== 8'h04) begin nerr++; $display("FAIL both_rise p=%h want 04", p0); end
    clr = 8'h04; tick(1); clr = 8'h00;
    nvec++; if (p0 !== 8'h00) begin nerr++; $display("FAIL both_clr p=%h want 00", p0); end
    pad = 8'h00; tick(3);
    clr = 8'h04; tick(1); clr = 8'h00;
    nvec++; if (p0 !== 8'h04) begin nerr++; $display("FAIL set_prio p=%h want 04", p0); end
    tick(1);
    nvec++; if (i0 !== 1'b1) begin nerr++; $display("FAIL both_irq i=%b want 1", i0); end
  endtask

  task automatic test_late_en;
    do_reset(8'hFF);
    pad = 8'hF7; tick(4);
    nvec++; if (p0 !== 8'h08) begin nerr++; $display("FAIL fall_pend p=%h want 08", p0); end
    tick(1);
    nvec++; if (i0 !== 1'b0) begin nerr++; $display("FAIL masked_irq i=%b want 0", i0); end
    en = 8'h08; tick(1);
    nvec++; if (i0 !== 1'b1) begin nerr++; $display("FAIL late_en i=%b want 1", i0); end
    clr = 8'h08; tick(1); clr = 8'h00;
    nvec++; if (p0 !== 8'h00) begin nerr++; $display("FAIL clr_pend p=%h want 00", p0); end
    tick(1);
    nvec++; if (i0 !== 1'b0) begin nerr++; $display("FAIL clr_irq i=%b want 0", i0); end
    edg = 8'hFF; both = 8'hFF; tick(3);
    nvec++; if (p0 !== 8'h00) begin nerr++; $display("FAIL cfg_noev p=%h want 00", p0); end
  endtask

  task automatic test_reset_mid;
    do_reset(8'h00);
    en = 8'h01; edg = 8'h01;
    pad = 8'h01; tick(5);
    nvec++; if (d5[0] !== 1'b0 || i0 !== 1'b1) begin nerr++; $display("FAIL mid_pre d5=%b i0=%b want 0 1", d5[0], i0); end
    rst = 1'b1; tick(1);
    nvec++; if (d5 !== 8'h00 || p5 !== 8'h00 || i5 !== 1'b0) begin nerr++; $display("FAIL mid_rst5 d=%h p=%h i=%b want 00 00 0", d5, p5, i5); end
    nvec++; if (d0 !== 8'h00 || p0 !== 8'h00 || i0 !== 1'b0) begin nerr++; $display("FAIL mid_rst0 d=%h p=%h i=%b want 00 00 0", d0, p0, i0); end
    rst = 1'b0; tick(2);
    nvec++; if (d5[0] !== 1'b0) begin nerr++; $display("FAIL rewarm_e2 d=%b want 0", d5[0]); end
    tick(1);
    nvec++; if (d5[0] !== 1'b1) begin nerr++; $display("FAIL rewarm_e3 d=%b want 1", d5[0]); end
    tick(2);
    nvec++; if (p0 !== 8'h00 || i0 !== 1'b0 || p5 !== 8'h00) begin nerr++; $display("FAIL rewarm_noev p0=%h i0=%b p5=%h want 00 0 00", p0, i0, p5); end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_filter();
    test_both_clr();
    test_late_en();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
